// File: rtl/sdram_rddata_assembler.sv
// Reassembles SDRAM read bursts: waits out CAS + synchronizer latency, captures
// the burst's words and packs them low-lane-first into AHB-width output words.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no burst pending; accepts rd_start_i
// S_WAIT    | READ issued, counting down CAS + synchronizer latency
// S_CAPTURE | sampling dq_i one word per cycle into the pack register
module sdram_rddata_assembler #(
    parameter int SDRAM_DQ_SIZE = 16,
    parameter int AHB_DATA_SIZE = 32,
    parameter int SYNC_LATENCY  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [1:0]               cl_i,
    input  logic                     rd_start_i,
    input  logic [3:0]               rd_len_i,
    input  logic [SDRAM_DQ_SIZE-1:0] dq_i,
    output logic [AHB_DATA_SIZE-1:0] rdata_o,
    output logic                     rvalid_o,
    output logic                     rlast_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int RATIO  = AHB_DATA_SIZE / SDRAM_DQ_SIZE;
    localparam int LANE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               lat_q, lat_d;
    logic [3:0]               len_q, len_d;
    logic [3:0]               wcnt_q, wcnt_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [AHB_DATA_SIZE-1:0] pack_q, pack_d;
    logic [AHB_DATA_SIZE-1:0] rdata_d;
    logic                     rvalid_d, rlast_d, busy_d, err_d;
    logic [AHB_DATA_SIZE-1:0] merged;
    logic                     last_word, lane_wrap;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            len_q    <= '0;
            wcnt_q   <= '0;
            lane_q   <= '0;
            pack_q   <= '0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            rlast_o  <= 1'b0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            lane_q   <= lane_d;
            pack_q   <= pack_d;
            rdata_o  <= rdata_d;
            rvalid_o <= rvalid_d;
            rlast_o  <= rlast_d;
            busy_o   <= busy_d;
            err_o    <= err_d;
        end
    end

    // Pack register with the current dq_i word dropped into the active lane
    always_comb begin
        merged = pack_q;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_q == LANE_W'(i)) begin
                merged[i*SDRAM_DQ_SIZE +: SDRAM_DQ_SIZE] = dq_i;
            end
        end
    end

    assign last_word = ((wcnt_q + 4'd1) == len_q);
    assign lane_wrap = (lane_q == LANE_W'(RATIO - 1));

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        lane_d   = lane_q;
        pack_d   = pack_q;
        rdata_d  = rdata_o;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_start_i) begin
                    if (cl_i != 2'd0 && rd_len_i != 4'd0 && rd_len_i <= 4'd8) begin
                        lat_d   = {1'b0, cl_i} + 3'(SYNC_LATENCY) - 3'd1;
                        len_d   = rd_len_i;
                        wcnt_d  = '0;
                        lane_d  = '0;
                        pack_d  = '0;
                        state_d = S_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                err_d = rd_start_i;
                lat_d = lat_q - 3'd1;
                // Leave one cycle early so word 0 is sampled at t0+cl+SYNC_LATENCY
                if (lat_q == 3'd1) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                err_d  = rd_start_i;
                wcnt_d = wcnt_q + 4'd1;
                if (lane_wrap || last_word) begin
                    rdata_d  = merged;
                    rvalid_d = 1'b1;
                    rlast_d  = last_word;
                    pack_d   = '0;
                    lane_d   = '0;
                end else begin
                    pack_d = merged;
                    lane_d = lane_q + LANE_W'(1);
                end
                if (last_word) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) || rlast_d;
    end

endmodule
